// File: rtl/canny_pkg.sv
// ============================================================================
// canny_pkg : shared types and constants for the blur window front end
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package canny_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_N = 9;
    localparam int WIN_W = PIX_W * WIN_N;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // LSB position of window tap (r,c); p00 sits in the top byte, p22 in the bottom.
    function automatic int win_lsb(input int r, input int c);
        return (WIN_N - 1 - (3 * r + c)) * PIX_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_buffer.sv
// ============================================================================
// line_buffer : single-port-write, registered-read pixel line store
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/blur_window_ctrl.sv
// ============================================================================
// blur_window_ctrl : raster scan to 3x3 window controller for the blur stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module blur_window_ctrl
    import canny_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [WIN_W-1:0] win,
    output logic             win_valid,
    output logic             out_valid,
    output logic             out_last,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);

    state_t           r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             r_flush;
    logic             r_last_win;
    logic             w_hs;
    logic [CW-1:0]    w_col_nxt;
    logic [CW-1:0]    w_rd_addr;
    logic [PIX_W-1:0] w_lb1_q;
    logic [PIX_W-1:0] w_lb2_q;

    assign w_hs      = pix_valid & pix_ready;
    assign w_col_nxt = (r_col == c_col_last) ? '0 : r_col + 1'b1;

    // Reads run one column ahead so the registered read lands on the handshake cycle.
    always_comb begin
        w_rd_addr = r_col;
        if (w_hs) begin
            w_rd_addr = w_col_nxt;
        end else if (r_state == ST_IDLE) begin
            w_rd_addr = '0;
        end
    end

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (w_hs),
        .wr_addr (r_col),
        .wr_data (pix_in),
        .rd_addr (w_rd_addr),
        .rd_data (w_lb1_q)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
        .clk     (clk),
        .wr_en   (w_hs),
        .wr_addr (r_col),
        .wr_data (w_lb1_q),
        .rd_addr (w_rd_addr),
        .rd_data (w_lb2_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_flush    <= 1'b0;
            r_last_win <= 1'b0;
            win        <= '0;
            busy       <= 1'b0;
            pix_ready  <= 1'b0;
            win_valid  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            r_last_win <= 1'b0;
            frame_done <= 1'b0;
            out_valid  <= win_valid;
            out_last   <= r_last_win;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_STREAM;
                        busy      <= 1'b1;
                        pix_ready <= 1'b1;
                        r_col     <= '0;
                        r_row     <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_hs) begin
                        win <= {win[win_lsb(0, 2) +: 2*PIX_W], w_lb2_q,
                                win[win_lsb(1, 2) +: 2*PIX_W], w_lb1_q,
                                win[win_lsb(2, 2) +: 2*PIX_W], pix_in};
                        win_valid <= (r_row >= RW'(2)) && (r_col >= CW'(2));
                        r_col     <= w_col_nxt;
                        if (r_col == c_col_last) begin
                            if (r_row == c_row_last) begin
                                r_row      <= '0;
                                r_state    <= ST_FLUSH;
                                r_flush    <= 1'b0;
                                pix_ready  <= 1'b0;
                                r_last_win <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    r_flush <= 1'b1;
                    if (r_flush) begin
                        r_state    <= ST_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    busy      <= 1'b0;
                    pix_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_blur_window_ctrl.sv
// ============================================================================
// tb_blur_window_ctrl : scoreboard bench for a 4x4 and a 5x3 instance
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_blur_window_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       drv_start = 1'b0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_pix = 8'd0;

    logic a_start, a_valid, a_busy, a_ready, a_wv, a_ov, a_ol, a_fd;
    logic b_start, b_valid, b_busy, b_ready, b_wv, b_ov, b_ol, b_fd;
    logic [71:0] a_win, b_win;

    assign a_start = drv_start & ~sel;
    assign a_valid = drv_valid & ~sel;
    assign b_start = drv_start & sel;
    assign b_valid = drv_valid & sel;

    blur_window_ctrl #(.IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy),
        .pix_in(drv_pix), .pix_valid(a_valid), .pix_ready(a_ready),
        .win(a_win), .win_valid(a_wv), .out_valid(a_ov), .out_last(a_ol),
        .frame_done(a_fd)
    );

    blur_window_ctrl #(.IMG_W(5), .IMG_H(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy),
        .pix_in(drv_pix), .pix_valid(b_valid), .pix_ready(b_ready),
        .win(b_win), .win_valid(b_wv), .out_valid(b_ov), .out_last(b_ol),
        .frame_done(b_fd)
    );

    logic sel_ready, sel_fd, sel_busy;
    assign sel_ready = sel ? b_ready : a_ready;
    assign sel_fd    = sel ? b_fd : a_fd;
    assign sel_busy  = sel ? b_busy : a_busy;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] win_b(input int k);
        return {8'(k-6), 8'(k-5), 8'(k-4), 8'(k-1), 8'(k), 8'(k+1), 8'(k+4), 8'(k+5), 8'(k+6)};
    endfunction

    // ---------------- scoreboards and monitors ----------------
    logic [71:0] sb_a[$];
    logic [71:0] sb_b[$];
    int  a_cyc = 0, a_hs_n = 0, a_last_hs = 0, a_outs = 0;
    int  b_cyc = 0, b_hs_n = 0, b_last_hs = 0, b_outs = 0;
    bit  a_prev_hs = 0, b_prev_hs = 0;

    always @(negedge clk) begin
        a_cyc++;
        if (!rst_n) begin
            a_hs_n = 0; a_outs = 0; a_prev_hs = 0;
        end else begin
            if (a_wv) begin
                check("a_wv_after_hs", 72'(a_prev_hs), 72'(1));
                if (sb_a.size() == 0) check("a_win_extra", 72'(sb_a.size()), 72'(1));
                else check("a_win", a_win, sb_a.pop_front());
            end
            if (a_ov) begin
                a_outs++;
                check("a_out_last", 72'(a_ol), 72'(a_outs == 4));
            end
            a_prev_hs = a_valid & a_ready;
            if (a_prev_hs) begin
                a_hs_n++;
                a_last_hs = a_cyc;
            end
            if (a_fd) begin
                check("a_done_latency", 72'(a_cyc - a_last_hs), 72'(3));
                check("a_hs_count", 72'(a_hs_n), 72'(16));
                a_hs_n = 0; a_outs = 0;
            end
        end
    end

    always @(negedge clk) begin
        b_cyc++;
        if (!rst_n) begin
            b_hs_n = 0; b_outs = 0; b_prev_hs = 0;
        end else begin
            if (b_wv) begin
                check("b_wv_after_hs", 72'(b_prev_hs), 72'(1));
                if (sb_b.size() == 0) check("b_win_extra", 72'(sb_b.size()), 72'(1));
                else check("b_win", b_win, sb_b.pop_front());
            end
            if (b_ov) begin
                b_outs++;
                check("b_out_last", 72'(b_ol), 72'(b_outs == 3));
            end
            b_prev_hs = b_valid & b_ready;
            if (b_prev_hs) begin
                b_hs_n++;
                b_last_hs = b_cyc;
            end
            if (b_fd) begin
                check("b_done_latency", 72'(b_cyc - b_last_hs), 72'(3));
                check("b_hs_count", 72'(b_hs_n), 72'(15));
                b_hs_n = 0; b_outs = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame();
        drv_start = 1'b1;
        @(posedge clk); #1;
        drv_start = 1'b0;
    endtask

    task automatic feed(input int n, input bit ramp, input bit gaps, input int mid_start);
        int to;
        for (int i = 0; i < n; i++) begin
            drv_pix   = ramp ? 8'(i) : 8'd100;
            drv_valid = 1'b1;
            drv_start = (i == mid_start);
            to = 0;
            while (!sel_ready && to < 20) begin
                @(posedge clk); #1;
                to++;
            end
            if (!sel_ready) begin
                check("ready_timeout", 72'(sel_ready), 72'(1));
                drv_valid = 1'b0;
                drv_start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            drv_start = 1'b0;
            if (gaps) begin
                drv_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        drv_valid = 1'b0;
    endtask

    task automatic wait_done(input bit restart);
        int to = 0;
        while (!sel_fd && to < 20) begin
            @(posedge clk); #1;
            to++;
        end
        check("frame_done_seen", 72'(sel_fd), 72'(1));
        check("busy_low_at_done", 72'(sel_busy), 72'(0));
        check("sb_drained", 72'(sel ? sb_b.size() : sb_a.size()), 72'(0));
        if (restart) begin
            drv_start = 1'b1;
            @(posedge clk); #1;
            drv_start = 1'b0;
            check("busy_after_restart", 72'(sel_busy), 72'(1));
            check("ready_after_restart", 72'(sel_ready), 72'(1));
        end
    endtask

    task automatic push_a_frame();
        for (int i = 0; i < 4; i++) sb_a.push_back({9{8'd100}});
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {a_busy, a_ready, a_wv, a_ov, a_ol, a_fd, a_win[65:0]}, 72'(0));
        check("reset_a_win", a_win, 72'(0));
        check("reset_b", {b_busy, b_ready, b_wv, b_ov, b_ol, b_fd, b_win[65:0]}, 72'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 flat frame
        sel = 1'b0;
        push_a_frame();
        start_frame();
        check("busy_after_start", 72'(a_busy), 72'(1));
        feed(16, 1'b0, 1'b0, -1);
        wait_done(1'b0);

        // start mid-frame is ignored; start with frame_done restarts
        push_a_frame();
        start_frame();
        feed(16, 1'b0, 1'b0, 5);
        wait_done(1'b1);
        push_a_frame();
        feed(16, 1'b0, 1'b0, -1);
        wait_done(1'b0);

        // 5x3 ramp, continuous then with gaps
        sel = 1'b1;
        for (int k = 6; k <= 8; k++) sb_b.push_back(win_b(k));
        start_frame();
        feed(15, 1'b1, 1'b0, -1);
        wait_done(1'b0);
        for (int k = 6; k <= 8; k++) sb_b.push_back(win_b(k));
        start_frame();
        feed(15, 1'b1, 1'b1, -1);
        wait_done(1'b0);

        // reset mid-frame, then a clean frame
        sel = 1'b0;
        start_frame();
        feed(7, 1'b0, 1'b0, -1);
        check("busy_before_abort", 72'(a_busy), 72'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", {a_busy, a_ready, a_wv, a_ov, a_ol, a_fd, a_win[65:0]}, 72'(0));
        check("abort_win", a_win, 72'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push_a_frame();
        start_frame();
        feed(16, 1'b0, 1'b0, -1);
        wait_done(1'b0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/blur_window_ctrl.md
BLUR_WINDOW_CTRL -- requirements
Module: blur_window_ctrl

Interface
REQ-001 The block SHALL use one clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Parameter IMG_W, default 640: pixels per line, legal range 3..4095.
REQ-003 Parameter IMG_H, default 480: lines per frame, legal range 3..4095.
REQ-004 Port `clk`, input, 1: rising-edge clock.
REQ-005 Port `rst_n`, input, 1: asynchronous active-low reset.
REQ-006 Port `start`, input, 1: single-cycle frame start request; honoured only in IDLE.
REQ-007 Port `busy`, output, 1: high in every state except IDLE.
REQ-008 Port `pix_in`, input, 8: raster-order input pixel.
REQ-009 Port `pix_valid`, input, 1: `pix_in` valid.
REQ-010 Port `pix_ready`, output, 1: block accepts a pixel; a handshake is `pix_valid & pix_ready`.
REQ-011 Port `win`, output, 72: 3x3 window to the blur datapath; p00 in [71:64] ... p22 in [7:0], row-major.
REQ-012 Port `win_valid`, output, 1: `win` holds a complete interior window.
REQ-013 Port `out_valid`, output, 1: `win_valid` delayed one cycle, aligned with the blur's registered output.
REQ-014 Port `out_last`, output, 1: high with the final `out_valid` of a frame.
REQ-015 Port `frame_done`, output, 1: one-cycle pulse on frame completion.

Function
REQ-016 FSM states SHALL be IDLE, STREAM and FLUSH.
- IDLE -> STREAM on `start`.
- STREAM -> FLUSH on the handshake of pixel (IMG_H-1, IMG_W-1).
- FLUSH -> IDLE after exactly 2 cycles.
REQ-017 `pix_ready` SHALL be 1 only in STREAM; there is no downstream backpressure.
REQ-018 Column counter `col` SHALL increment per handshake and wrap from IMG_W-1 to 0; on wrap, row counter `row` SHALL increment. Both SHALL clear on entering STREAM.
REQ-019 Two line buffers of depth IMG_W SHALL hold the previous two lines, addressed by `col`, and SHALL be written only on a handshake.
REQ-020 On a handshake at (r,c), the window SHALL shift left, with new column sources as follows.
- p02 = line buffer 2 at `c`.
- p12 = line buffer 1 at `c`.
- p22 = `pix_in`.
REQ-021 `win_valid` SHALL assert in the cycle after a handshake at (r,c) if and only if r>=2 and c>=2; otherwise it SHALL be 0. Each frame therefore yields (IMG_W-2)*(IMG_H-2) windows.
REQ-022 Gaps in `pix_valid` SHALL freeze the counters, the window and the line buffers; `win_valid` SHALL be 0 during gaps.
REQ-023 `out_last` SHALL assert in the cycle after the `win_valid` for pixel (IMG_H-1, IMG_W-1).
REQ-024 `frame_done` SHALL pulse in the first IDLE cycle after FLUSH, i.e. 3 cycles after the last handshake; `busy` SHALL fall in the same cycle.
REQ-025 `start` while busy SHALL be ignored; `start` coincident with `frame_done` SHALL begin a new frame.
REQ-026 Window content across line boundaries is don't-care; only windows flagged valid are defined.

Reset
REQ-027 Asserting `rst_n` low SHALL immediately force the following, including mid-frame: state=IDLE, row=col=0, `win`=0, and `busy`, `pix_ready`, `win_valid`, `out_valid`, `out_last`, `frame_done` all 0.
REQ-028 Line-buffer contents SHALL NOT be reset.
REQ-029 The first frame after reset release SHALL be correct with no stale windows flagged.

Structure
REQ-030 Shared package `canny_pkg` SHALL hold the FSM state enum, PIX_W=8 and the window packing constants.
REQ-031 One sub-module `line_buffer` (depth IMG_W, width 8, registered read) SHALL be instantiated twice.

Verification
REQ-032 IMG_W=4, IMG_H=4, every pixel 100, continuous valid -> 4 `win_valid` pulses, every `win` byte =100, `out_last` on the 4th `out_valid`, `frame_done` 3 cycles after the 16th handshake.
REQ-033 IMG_W=5, IMG_H=3, pixel value = index 0..14 -> windows centred on pixels 6, 7, 8; the first window is p00..p22 = 0,1,2,5,6,7,10,11,12.
REQ-034 Same stimulus as REQ-033 with `pix_valid` toggling 1,0,1,0 -> identical window sequence and `win_valid` never high during a gap.
REQ-035 `start` pulsed mid-frame -> no counter or state change; `start` coincident with `frame_done` -> `busy` high the next cycle.
REQ-036 `rst_n` low after 7 handshakes -> all outputs 0 at once; a subsequent 4x4 frame reproduces the REQ-032 result.
